// File: rtl/arbitro_banco_registrador.sv
// Write-port controller for the 64 x 32-bit register bank.
// After reset it writes R0 = 0 and R1 = VALOR_INIT_R1, then raises pronto and
// arbitrates the single bank write port round-robin between the CPU writeback
// stage and the I/O input unit. All outputs are registered.
//
// Ports:
//   clock, reset               clock; asynchronous active-low reset
//   req_cpu/end_cpu/dado_cpu   CPU write request, held until ack_cpu
//   ack_cpu                    one-cycle pulse, CPU request accepted
//   req_es/end_es/dado_es      I/O write request, held until ack_es
//   ack_es                     one-cycle pulse, I/O request accepted
//   end_escrita, dados_escrita bank write address / data
//   EscreveReg                 bank write enable
//   pronto                     initialization complete
module arbitro_banco_registrador #(
    parameter int unsigned LARGURA_DADO  = 32,
    parameter int unsigned LARGURA_END   = 6,
    parameter int unsigned VALOR_INIT_R1 = 13249
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_cpu,
    input  logic [LARGURA_END-1:0]  end_cpu,
    input  logic [LARGURA_DADO-1:0] dado_cpu,
    output logic                    ack_cpu,
    input  logic                    req_es,
    input  logic [LARGURA_END-1:0]  end_es,
    input  logic [LARGURA_DADO-1:0] dado_es,
    output logic                    ack_es,
    output logic [LARGURA_END-1:0]  end_escrita,
    output logic [LARGURA_DADO-1:0] dados_escrita,
    output logic                    EscreveReg,
    output logic                    pronto
);

    typedef enum logic [1:0] {StInit0, StInit1, StAtivo} estado_e;

    estado_e                 estado_q;
    logic                    ultimo_es_q;   // 1: last grant went to the I/O unit
    logic                    ack_cpu_q;
    logic                    ack_es_q;
    logic                    escreve_q;
    logic                    pronto_q;
    logic [LARGURA_END-1:0]  end_q;
    logic [LARGURA_DADO-1:0] dados_q;

    logic                    eleg_cpu;
    logic                    eleg_es;
    logic                    concede_cpu_d;
    logic                    concede_es_d;
    logic [LARGURA_END-1:0]  end_venc_d;
    logic [LARGURA_DADO-1:0] dado_venc_d;

    // A requester whose ack is high is still presenting the data just written
    // (or its next request), so it is skipped for one cycle to avoid a stale
    // re-grant. On a tie the requester not granted last wins.
    always_comb begin
        eleg_cpu      = req_cpu && !ack_cpu_q;
        eleg_es       = req_es && !ack_es_q;
        concede_cpu_d = eleg_cpu && (!eleg_es || ultimo_es_q);
        concede_es_d  = eleg_es && !concede_cpu_d;
        end_venc_d    = concede_cpu_d ? end_cpu : end_es;
        dado_venc_d   = concede_cpu_d ? dado_cpu : dado_es;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= StInit0;
            ultimo_es_q <= 1'b1;
            ack_cpu_q   <= 1'b0;
            ack_es_q    <= 1'b0;
            escreve_q   <= 1'b0;
            pronto_q    <= 1'b0;
            end_q       <= '0;
            dados_q     <= '0;
        end else begin
            ack_cpu_q <= 1'b0;
            ack_es_q  <= 1'b0;
            escreve_q <= 1'b0;
            unique case (estado_q)
                StInit0: begin
                    escreve_q <= 1'b1;
                    end_q     <= '0;
                    dados_q   <= '0;
                    estado_q  <= StInit1;
                end
                StInit1: begin
                    escreve_q <= 1'b1;
                    end_q     <= LARGURA_END'(1);
                    dados_q   <= LARGURA_DADO'(VALOR_INIT_R1);
                    pronto_q  <= 1'b1;
                    estado_q  <= StAtivo;
                end
                StAtivo: begin
                    if (concede_cpu_d || concede_es_d) begin
                        end_q       <= end_venc_d;
                        dados_q     <= dado_venc_d;
                        // R0 is only written during init; the grant is still acked.
                        escreve_q   <= (end_venc_d != '0);
                        ack_cpu_q   <= concede_cpu_d;
                        ack_es_q    <= concede_es_d;
                        ultimo_es_q <= concede_es_d;
                    end
                end
                default: estado_q <= StInit0;
            endcase
        end
    end

    assign ack_cpu       = ack_cpu_q;
    assign ack_es        = ack_es_q;
    assign EscreveReg    = escreve_q;
    assign end_escrita   = end_q;
    assign dados_escrita = dados_q;
    assign pronto        = pronto_q;

endmodule

// File: doc/arbitro_banco_registrador.md
# arbitro_banco_registrador

Write-port controller for the 64 x 32-bit register bank. It owns the bank's single write port (end_escrita, dados_escrita, EscreveReg) and runs a two-write initialization sequence after reset: R0 = 0, then R1 = RAM size constant. It then arbitrates round-robin between two requesters: the CPU writeback stage and the I/O input unit. It sits between those requesters and the bank; read ports are not touched.

## Interface
- LARGURA_DADO, 32, data width of the bank
- LARGURA_END, 6, register address width (64 registers)
- VALOR_INIT_R1, 13249, value written to R1 during initialization (last valid RAM index)

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req_cpu  in  1  CPU write request; held with end_cpu/dado_cpu until ack_cpu
- end_cpu  in  LARGURA_END  CPU destination register
- dado_cpu  in  LARGURA_DADO  CPU write data
- ack_cpu  out  1  one-cycle pulse: CPU request accepted
- req_es  in  1  I/O write request; same protocol as CPU
- end_es  in  LARGURA_END  I/O destination register
- dado_es  in  LARGURA_DADO  I/O write data
- ack_es  out  1  one-cycle pulse: I/O request accepted
- end_escrita  out  LARGURA_END  to bank write address
- dados_escrita  out  LARGURA_DADO  to bank write data
- EscreveReg  out  1  to bank write enable
- pronto  out  1  high once initialization is complete

## Operation
- Reset values: EscreveReg=0, end_escrita=0, dados_escrita=0, ack_cpu=0, ack_es=0, pronto=0. FSM is in INIT0. The round-robin pointer is set to "last granted = ES", so the CPU wins the first tie.
- FSM states and transitions:
  - INIT0 -> INIT1: registers the write R0 = 0.
  - INIT1 -> ATIVO: registers the write R1 = VALOR_INIT_R1 and sets pronto=1.
  - ATIVO: stays in ATIVO until reset.
- In INIT0 and INIT1, requests are ignored and no ack is issued.
- ATIVO, at each posedge:
  - A requester is eligible when its req=1 and its ack is currently 0. This prevents re-granting stale data in the ack cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one not granted last is granted and the pointer flips.
- Effect of a grant, registered at that edge:
  - end_escrita and dados_escrita take the winner's inputs.
  - EscreveReg=1.
  - The winner's ack=1 for exactly one cycle.
  - With no grant, EscreveReg=0 and the address/data outputs hold their previous values.
- R0 protection: a granted request with address 0 still produces the ack, but EscreveReg stays 0. R0 is only ever written by INIT0.
- Requester protocol: hold req, address and data stable until ack is seen high. In the ack cycle, either drop req or present new address/data with req held for the next write.
- Only one write is issued per cycle. There is no buffering; a waiting requester simply stays stalled.

## Timing
- Reset deassert, then:
  - edge 1: EscreveReg=1, end_escrita=0, dados_escrita=0.
  - edge 2: end_escrita=1, dados_escrita=VALOR_INIT_R1, pronto=1.
  - edge 3: first arbitration edge; EscreveReg=0 if no requests.
- Grant latency: request sampled at edge k; write outputs and ack are valid from edge k until edge k+1; the bank stores the data at edge k+1.
- Throughput:
  - A single requester gets at most 1 write per 2 cycles.
  - Two contending requesters alternate, giving 1 write per cycle in total.
- Reset asserted mid-operation:
  - All outputs clear asynchronously and any in-flight write is dropped.
  - The initialization sequence repeats after deassert.
  - A requester that was not acked must re-hold its request.

## Test plan
- Reset release with no requests -> edge1: EscreveReg=1, end=0, dado=0; edge2: end=1, dado=13249, pronto=1; edge3: EscreveReg=0.
- After pronto, req_cpu with end_cpu=5, dado_cpu=0xDEADBEEF, dropped on ack -> exactly one cycle with EscreveReg=1, end=5, dado=0xDEADBEEF, and ack_cpu=1 in that same cycle; ack_es stays 0.
- req_cpu and req_es both held high continuously, with new data after each ack -> grants CPU, ES, CPU, ES... EscreveReg=1 every cycle, and each ack pulses every second cycle.
- req_es alone held high continuously -> ack_es and EscreveReg toggle 1,0,1,0; no write repeats stale data.
- req_cpu with end_cpu=0, dado_cpu=0x1234 -> ack_cpu pulses once; EscreveReg stays 0.
- reset driven low during a CPU grant, with req_cpu high during the init cycles -> outputs go to 0 immediately; after release the init writes R0/R1 are repeated with no ack during INIT0/INIT1; the CPU request is granted at edge 3.
